// File: rtl/seq_match_pkg.sv
// seq_match_pkg: shared types, default widths and config helpers for the
// seq_match_sched block.
package seq_match_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int unsigned DEF_NCH = 32'd4;
  localparam int unsigned DEF_PW  = 32'd8;
  localparam int unsigned DEF_CW  = 32'd8;

  // A pattern length is usable when it selects at least one bit and no more
  // bits than the history holds.
  function automatic logic len_is_legal(input int unsigned len, input int unsigned pw);
    return (len >= 32'd1) && (len <= pw);
  endfunction

endpackage

// File: rtl/seq_match_sched_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant. Grants the lowest-index requester
// strictly after the last granted channel, wrapping; the pointer only moves
// when a grant is actually issued.
module rr_arbiter #(
  parameter int unsigned  NCH = 32'd4,
  localparam int unsigned IW  = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en_i,
  input  logic [NCH-1:0] req_i,
  output logic [NCH-1:0] gnt_o,
  output logic [IW-1:0]  gnt_idx_o,
  output logic           gnt_vld_o
);

  logic [IW-1:0] last_q;
  logic [IW-1:0] last_d;
  int unsigned   idx_s;
  logic          hit_s;

  // Scan channels starting just after the last grant; first requester wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    idx_s     = 32'd0;
    hit_s     = 1'b0;
    for (int unsigned k = 32'd1; k <= NCH; k++) begin
      idx_s     = (32'(last_q) + k) % NCH;
      hit_s     = en_i && !gnt_vld_o && req_i[idx_s[IW-1:0]];
      gnt_o     = gnt_o | ({{(NCH-1){1'b0}}, hit_s} << idx_s[IW-1:0]);
      gnt_idx_o = hit_s ? idx_s[IW-1:0] : gnt_idx_o;
      gnt_vld_o = gnt_vld_o | hit_s;
    end
    last_d = gnt_vld_o ? gnt_idx_o : last_q;
  end

  // Pointer register; reset so that channel 0 is first in line.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= IW'(NCH - 32'd1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/seq_match_sched.sv
// seq_match_sched: round-robin scheduler sharing one programmable serial
// pattern matcher across NCH bit-serial channels.
// Optional feature macro: SEQ_MATCH_CNT_EN adds saturating per-channel
// match counters readable through cnt_sel/cnt_val; without it cnt_val is 0.
module seq_match_sched
  import seq_match_pkg::*;
#(
  parameter int unsigned  NCH = DEF_NCH,
  parameter int unsigned  PW  = DEF_PW,
  parameter int unsigned  CW  = DEF_CW,
  localparam int unsigned LW  = $clog2(PW) + 1,
  localparam int unsigned IW  = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_we,
  input  logic [PW-1:0]  cfg_pattern,
  input  logic [LW-1:0]  cfg_len,
  input  logic           cfg_overlap,
  input  logic [NCH-1:0] in_valid,
  input  logic [NCH-1:0] in_bit,
  output logic [NCH-1:0] in_ready,
  output logic           match_valid,
  output logic [IW-1:0]  match_ch,
  output logic           armed,
  input  logic [IW-1:0]  cnt_sel,
  output logic [CW-1:0]  cnt_val
);

  state_e        state_q, state_d;
  logic          cfg_legal_s, cfg_take_s, arb_en_s;
  logic [PW-1:0] cfg_pat_q;
  logic [LW-1:0] cfg_len_q;
  logic          cfg_ovl_q;
  logic [PW-1:0] hist_q [NCH];
  logic [LW-1:0] fill_q [NCH];
  logic          gnt_vld_s;
  logic [IW-1:0] gnt_idx_s;
  logic [PW-1:0] new_hist_s, mask_s;
  logic [LW-1:0] new_fill_s;
  logic          hit_s;
  logic          match_valid_q;
  logic [IW-1:0] match_ch_q;
  logic          armed_q;

  assign cfg_legal_s = len_is_legal(32'(cfg_len), PW);

  // Next-state logic; a legal config write also latches the new settings.
  always_comb begin
    state_d    = state_q;
    cfg_take_s = 1'b0;
    case (state_q)
      UNCFG: begin
        if (cfg_we && cfg_legal_s) begin
          state_d    = RUN;
          cfg_take_s = 1'b1;
        end else begin
          state_d = UNCFG;
        end
      end
      RUN: begin
        if (cfg_we && cfg_legal_s) begin
          state_d    = FLUSH;
          cfg_take_s = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH:   state_d = RUN;
      default: state_d = UNCFG;
    endcase
    // No input is consumed while a config write is on the bus.
    arb_en_s = (state_q == RUN) && !cfg_we;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= UNCFG;
    else       state_q <= state_d;
  end

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .en_i      (arb_en_s),
    .req_i     (in_valid),
    .gnt_o     (in_ready),
    .gnt_idx_o (gnt_idx_s),
    .gnt_vld_o (gnt_vld_s)
  );

  // Compare the granted channel's updated history against the pattern.
  always_comb begin
    new_hist_s = {hist_q[gnt_idx_s][PW-2:0], in_bit[gnt_idx_s]};
    if (fill_q[gnt_idx_s] == LW'(PW)) new_fill_s = fill_q[gnt_idx_s];
    else                              new_fill_s = fill_q[gnt_idx_s] + LW'(1);
    mask_s = '0;
    for (int unsigned b = 32'd0; b < PW; b++) mask_s[b] = (b < 32'(cfg_len_q));
    hit_s = gnt_vld_s && (new_fill_s >= cfg_len_q) &&
            (((new_hist_s ^ cfg_pat_q) & mask_s) == '0);
  end

  // Latched configuration.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_pat_q <= '0;
      cfg_len_q <= '0;
      cfg_ovl_q <= 1'b0;
    end else if (cfg_take_s) begin
      cfg_pat_q <= cfg_pattern;
      cfg_len_q <= cfg_len;
      cfg_ovl_q <= cfg_overlap;
    end else begin
      cfg_pat_q <= cfg_pat_q;
    end
  end

  // Per-channel history and fill; a non-overlapping match restarts the channel.
  always_ff @(posedge clk) begin
    if (reset || (state_q == FLUSH)) begin
      for (int unsigned c = 32'd0; c < NCH; c++) begin
        hist_q[c] <= '0;
        fill_q[c] <= '0;
      end
    end else if (gnt_vld_s) begin
      if (hit_s && !cfg_ovl_q) begin
        hist_q[gnt_idx_s] <= '0;
        fill_q[gnt_idx_s] <= '0;
      end else begin
        hist_q[gnt_idx_s] <= new_hist_s;
        fill_q[gnt_idx_s] <= new_fill_s;
      end
    end else begin
      fill_q[gnt_idx_s] <= fill_q[gnt_idx_s];
    end
  end

  // Registered match pulse, channel id and armed flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      match_valid_q <= 1'b0;
      match_ch_q    <= '0;
      armed_q       <= 1'b0;
    end else begin
      match_valid_q <= hit_s;
      match_ch_q    <= hit_s ? gnt_idx_s : match_ch_q;
      armed_q       <= (state_d != UNCFG);
    end
  end

  assign match_valid = match_valid_q;
  assign match_ch    = match_ch_q;
  assign armed       = armed_q;

`ifdef SEQ_MATCH_CNT_EN
  logic [CW-1:0] cnt_q [NCH];

  // Saturating match counters, updated on the same edge as the match pulse.
  always_ff @(posedge clk) begin
    if (reset || (state_q == FLUSH)) begin
      for (int unsigned c = 32'd0; c < NCH; c++) cnt_q[c] <= '0;
    end else if (hit_s && (cnt_q[gnt_idx_s] != {CW{1'b1}})) begin
      cnt_q[gnt_idx_s] <= cnt_q[gnt_idx_s] + CW'(1);
    end else begin
      cnt_q[gnt_idx_s] <= cnt_q[gnt_idx_s];
    end
  end

  assign cnt_val = cnt_q[cnt_sel];
`else
  logic cnt_sel_unused_s;
  assign cnt_sel_unused_s = ^cnt_sel;
  assign cnt_val          = '0;
`endif

endmodule

// File: tb/tb_seq_match_sched.sv
// tb_seq_match_sched: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the scheduler and matcher.
module tb_seq_match_sched;

  localparam int unsigned NCH = 4;
  localparam int unsigned PW  = 8;
`ifdef SEQ_MATCH_CNT_EN
  localparam int unsigned CW  = 2;
`else
  localparam int unsigned CW  = 8;
`endif
  localparam int unsigned LW  = $clog2(PW) + 1;
  localparam int unsigned IW  = $clog2(NCH);

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           cfg_we = 1'b0;
  logic [PW-1:0]  cfg_pattern = '0;
  logic [LW-1:0]  cfg_len = '0;
  logic           cfg_overlap = 1'b0;
  logic [NCH-1:0] in_valid = '0;
  logic [NCH-1:0] in_bit = '0;
  logic [NCH-1:0] in_ready;
  logic           match_valid;
  logic [IW-1:0]  match_ch;
  logic           armed;
  logic [IW-1:0]  cnt_sel = '0;
  logic [CW-1:0]  cnt_val;

  int total = 0;
  int bad   = 0;

  seq_match_sched #(.NCH(NCH), .PW(PW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .in_bit(in_bit), .in_ready(in_ready), .match_valid(match_valid),
    .match_ch(match_ch), .armed(armed), .cnt_sel(cnt_sel), .cnt_val(cnt_val)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One cycle: drive inputs, sample in_ready before the edge, match after it.
  task automatic step(input logic [NCH-1:0] v, input logic [NCH-1:0] b, input logic we,
                      output logic [NCH-1:0] rdy, output logic mv, output logic [IW-1:0] mc);
    in_valid = v; in_bit = b; cfg_we = we;
    #1;
    rdy = in_ready;
    @(posedge clk);
    #1;
    mv = match_valid; mc = match_ch;
    in_valid = '0; cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = '0; cfg_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic do_cfg(input logic [PW-1:0] pat, input logic [LW-1:0] len, input logic ovl);
    logic [NCH-1:0] r; logic m; logic [IW-1:0] c;
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    step('0, '0, 1'b1, r, m, c);
    step('0, '0, 1'b0, r, m, c);
  endtask

  task automatic test_reset();
    do_reset();
    in_valid = '1;
    #1;
    total++; if (in_ready !== '0)   $display("FAIL reset_ready got=%b exp=0", in_ready);
    total++; if (match_valid !== 1'b0) $display("FAIL reset_mv got=%b exp=0", match_valid);
    total++; if (match_ch !== '0)   $display("FAIL reset_mch got=%0d exp=0", match_ch);
    total++; if (armed !== 1'b0)    $display("FAIL reset_armed got=%b exp=0", armed);
    total++; if (cnt_val !== '0)    $display("FAIL reset_cnt got=%0d exp=0", cnt_val);
    bad += (in_ready !== '0) + (match_valid !== 1'b0) + (match_ch !== '0) + (armed !== 1'b0) + (cnt_val !== '0);
    in_valid = '0;
  endtask

  task automatic run_101(input logic ovl, input logic [4:0] exp_m, input string nm);
    logic [NCH-1:0] rdy; logic mv; logic [IW-1:0] mc;
    logic [4:0] bits;
    bits = 5'b10101;
    do_reset(); do_cfg(8'b0000_0101, 4'd3, ovl);
    for (int k = 0; k < 5; k++) begin
      step(NCH'(1), NCH'(bits[k]), 1'b0, rdy, mv, mc);
      total++;
      if (rdy !== NCH'(1)) begin bad++; $display("FAIL %s_ready k=%0d got=%b exp=0001", nm, k, rdy); end
      total++;
      if (mv !== exp_m[k] || (exp_m[k] && mc !== '0)) begin
        bad++; $display("FAIL %s_match k=%0d got=%b/%0d exp=%b/0", nm, k, mv, mc, exp_m[k]);
      end
    end
  endtask

  task automatic test_overlap();     run_101(1'b1, 5'b10100, "overlap");    endtask
  task automatic test_non_overlap(); run_101(1'b0, 5'b00100, "nonoverlap"); endtask

  task automatic test_fairness();
    logic [NCH-1:0] rdy; logic mv; logic [IW-1:0] mc;
    int exp_a [6] = '{0, 1, 2, 3, 0, 1};
    int exp_b [4] = '{0, 1, 3, 0};
    do_reset(); do_cfg(8'hFF, 4'd8, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step(4'b1111, '0, 1'b0, rdy, mv, mc);
      total++;
      if (rdy !== (NCH'(1) << exp_a[k])) begin bad++; $display("FAIL fair_all k=%0d got=%b exp_ch=%0d", k, rdy, exp_a[k]); end
    end
    do_reset(); do_cfg(8'hFF, 4'd8, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(4'b1011, '0, 1'b0, rdy, mv, mc);
      total++;
      if (rdy !== (NCH'(1) << exp_b[k])) begin bad++; $display("FAIL fair_drop k=%0d got=%b exp_ch=%0d", k, rdy, exp_b[k]); end
    end
  endtask

  task automatic test_independence();
    logic [NCH-1:0] rdy; logic mv; logic [IW-1:0] mc;
    int   chs [6] = '{1, 3, 1, 3, 1, 3};
    logic bts [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic exm [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset(); do_cfg(8'b0000_0101, 4'd3, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step(NCH'(1) << chs[k], NCH'(bts[k]) << chs[k], 1'b0, rdy, mv, mc);
      total++;
      if (rdy !== (NCH'(1) << chs[k])) begin bad++; $display("FAIL indep_ready k=%0d got=%b exp_ch=%0d", k, rdy, chs[k]); end
      total++;
      if (mv !== exm[k] || (exm[k] && mc !== IW'(chs[k]))) begin
        bad++; $display("FAIL indep_match k=%0d got=%b/%0d exp=%b/%0d", k, mv, mc, exm[k], chs[k]);
      end
    end
  endtask

  task automatic test_reconfig();
    logic [NCH-1:0] rdy; logic mv; logic [IW-1:0] mc;
    logic [NCH-1:0] er [5] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001};
    logic           ew [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic           eb [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic           em [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset(); do_cfg(8'b0000_0101, 4'd3, 1'b0);
    step(NCH'(1), NCH'(1), 1'b0, rdy, mv, mc);
    step(NCH'(1), NCH'(0), 1'b0, rdy, mv, mc);
    for (int k = 0; k < 5; k++) begin
      step(NCH'(1), NCH'(eb[k]), ew[k], rdy, mv, mc);
      total++;
      if (rdy !== er[k]) begin bad++; $display("FAIL reconfig_ready k=%0d got=%b exp=%b", k, rdy, er[k]); end
      total++;
      if (mv !== em[k]) begin bad++; $display("FAIL reconfig_match k=%0d got=%b exp=%b", k, mv, em[k]); end
      if (k == 0) begin
        total++;
        if (armed !== 1'b1) begin bad++; $display("FAIL reconfig_armed got=%b exp=1", armed); end
      end
    end
  endtask

  task automatic test_illegal_len();
    logic [NCH-1:0] rdy; logic mv; logic [IW-1:0] mc;
    do_reset();
    cfg_pattern = 8'b0000_0101; cfg_overlap = 1'b1;
    cfg_len = 4'd0;
    step(NCH'(1), NCH'(1), 1'b1, rdy, mv, mc);
    total++; if (armed !== 1'b0) begin bad++; $display("FAIL illegal_len0_armed got=%b exp=0", armed); end
    total++; if (rdy !== '0) begin bad++; $display("FAIL uncfg_ready got=%b exp=0", rdy); end
    cfg_len = 4'd9;
    step('0, '0, 1'b1, rdy, mv, mc);
    total++; if (armed !== 1'b0) begin bad++; $display("FAIL illegal_len9_armed got=%b exp=0", armed); end
    do_cfg(8'b0000_0101, 4'd3, 1'b1);
    total++; if (armed !== 1'b1) begin bad++; $display("FAIL legal_armed got=%b exp=1", armed); end
    step(NCH'(1), NCH'(1), 1'b0, rdy, mv, mc);
    step(NCH'(1), NCH'(0), 1'b0, rdy, mv, mc);
    cfg_len = 4'd0;
    step(NCH'(1), NCH'(1), 1'b1, rdy, mv, mc);
    total++; if (rdy !== '0) begin bad++; $display("FAIL run_illegal_ready got=%b exp=0", rdy); end
    step(NCH'(1), NCH'(1), 1'b0, rdy, mv, mc);
    total++;
    if (rdy !== NCH'(1) || mv !== 1'b1) begin
      bad++; $display("FAIL run_illegal_kept got=%b/%b exp=0001/1", rdy, mv);
    end
  endtask

  task automatic test_reset_abort();
    logic [NCH-1:0] rdy; logic mv; logic [IW-1:0] mc;
    do_reset(); do_cfg(8'b0000_0101, 4'd3, 1'b1);
    step(NCH'(1), NCH'(1), 1'b0, rdy, mv, mc);
    step(NCH'(1), NCH'(0), 1'b0, rdy, mv, mc);
    reset = 1'b1;
    step(NCH'(1), NCH'(1), 1'b0, rdy, mv, mc);
    reset = 1'b0;
    total++; if (mv !== 1'b0) begin bad++; $display("FAIL reset_abort_mv got=%b exp=0", mv); end
    total++; if (armed !== 1'b0) begin bad++; $display("FAIL reset_abort_armed got=%b exp=0", armed); end
  endtask

  task automatic test_counters();
    logic [NCH-1:0] rdy; logic mv; logic [IW-1:0] mc;
    int nm, exp_cnt, cmax;
    cmax = (1 << CW) - 1;
    nm = 0;
    cnt_sel = '0;
    do_reset(); do_cfg(8'b0000_0101, 4'd3, 1'b1);
    for (int k = 0; k < 11; k++) begin
      step(NCH'(1), NCH'((k % 2) == 0), 1'b0, rdy, mv, mc);
      if (k >= 2 && (k % 2) == 0) nm++;
`ifdef SEQ_MATCH_CNT_EN
      exp_cnt = (nm > cmax) ? cmax : nm;
`else
      exp_cnt = 0;
`endif
      total++;
      if (cnt_val !== CW'(exp_cnt)) begin bad++; $display("FAIL cnt k=%0d got=%0d exp=%0d", k, cnt_val, exp_cnt); end
    end
    cnt_sel = IW'(1);
    #1;
    total++; if (cnt_val !== '0) begin bad++; $display("FAIL cnt_other got=%0d exp=0", cnt_val); end
    cnt_sel = '0;
    do_reset();
    total++; if (cnt_val !== '0) begin bad++; $display("FAIL cnt_reset got=%0d exp=0", cnt_val); end
  endtask

  task automatic test_random();
    logic [NCH-1:0] rdy, v, b, exp_rdy; logic mv, exp_m; logic [IW-1:0] mc;
    logic [PW-1:0] pat; int len; logic ovl;
    bit hq [NCH][$];
    int last, g, sz;
    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(1, 3); pat = PW'($urandom); ovl = 1'($urandom_range(0, 1));
      do_reset(); do_cfg(pat, LW'(len), ovl);
      last = NCH - 1;
      for (int c = 0; c < NCH; c++) hq[c].delete();
      for (int t = 0; t < 150; t++) begin
        v = NCH'($urandom); b = NCH'($urandom);
        g = -1;
        for (int k = 1; k <= NCH; k++)
          if (g < 0 && v[(last + k) % NCH]) g = (last + k) % NCH;
        exp_rdy = '0; exp_m = 1'b0;
        if (g >= 0) begin
          exp_rdy[g] = 1'b1; last = g;
          hq[g].push_back(b[g]);
          sz = hq[g].size();
          if (sz >= len) begin
            exp_m = 1'b1;
            for (int j = 0; j < len; j++) if (hq[g][sz-1-j] != pat[j]) exp_m = 1'b0;
          end
          if (exp_m && !ovl) hq[g].delete();
          if (hq[g].size() > PW) void'(hq[g].pop_front());
        end
        step(v, b, 1'b0, rdy, mv, mc);
        total++;
        if (rdy !== exp_rdy) begin bad++; $display("FAIL rand_ready r=%0d t=%0d got=%b exp=%b", r, t, rdy, exp_rdy); end
        total++;
        if (mv !== exp_m || (exp_m && mc !== IW'(g))) begin
          bad++; $display("FAIL rand_match r=%0d t=%0d got=%b/%0d exp=%b/%0d", r, t, mv, mc, exp_m, g);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_fairness();
    test_independence();
    test_reconfig();
    test_illegal_len();
    test_reset_abort();
    test_counters();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
